// File: rtl/branching_unit.sv
// Branch-resolution stage: picks the registered next PC and the PC+PC_INC link value.
// Optional macro BRANCH_STATS_EN adds saturating taken/branch cycle counters.
module branching_unit #(
    parameter int WIDTH  = 32,
    parameter int PC_INC = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] read_data1,
    input  logic [WIDTH-1:0] label,
    input  logic [4:0]       fcode,
    input  logic             branch,
    input  logic             branchSrc,
    input  logic             sign,
    input  logic             zero,
    input  logic             carry,
`ifdef BRANCH_STATS_EN
    output logic [31:0]      taken_count,
    output logic [31:0]      branch_count,
`endif
    output logic [WIDTH-1:0] next_pc,
    output logic [WIDTH-1:0] writeRegData,
    output logic             taken,
    output logic             illegal
);

    localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(PC_INC);

    logic [WIDTH-1:0] seq;
    logic [WIDTH-1:0] target;
    logic             cond;
    logic             take;

    logic [WIDTH-1:0] next_pc_q, next_pc_d;
    logic [WIDTH-1:0] link_q, link_d;
    logic             taken_q, taken_d;
    logic             illegal_q, illegal_d;

    always_comb begin
        seq    = pc + PC_STEP;
        target = branchSrc ? label : read_data1;
        cond   = 1'b0;
        case (fcode)
            5'd0:    cond = 1'b1;
            5'd1:    cond = carry;
            5'd2:    cond = ~carry;
            5'd3:    cond = zero;
            5'd4:    cond = sign;
            5'd5:    cond = ~zero;
            5'd6:    cond = 1'b1;
            default: cond = 1'b0;
        endcase
        take = branch & cond;

        next_pc_d = take ? target : seq;
        // Link value is always produced; only bl consumers actually write it back.
        link_d    = seq;
        taken_d   = take;
        illegal_d = branch & (fcode > 5'd6);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            next_pc_q <= '0;
            link_q    <= '0;
            taken_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            next_pc_q <= next_pc_d;
            link_q    <= link_d;
            taken_q   <= taken_d;
            illegal_q <= illegal_d;
        end
    end

    assign next_pc      = next_pc_q;
    assign writeRegData = link_q;
    assign taken        = taken_q;
    assign illegal      = illegal_q;

`ifdef BRANCH_STATS_EN
    logic [31:0] taken_count_q, taken_count_d;
    logic [31:0] branch_count_q, branch_count_d;

    // Both counters stick at all-ones instead of wrapping.
    always_comb begin
        taken_count_d  = taken_count_q;
        branch_count_d = branch_count_q;
        if (take && (taken_count_q != 32'hFFFF_FFFF))
            taken_count_d = taken_count_q + 32'd1;
        if (branch && (branch_count_q != 32'hFFFF_FFFF))
            branch_count_d = branch_count_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taken_count_q  <= '0;
            branch_count_q <= '0;
        end else begin
            taken_count_q  <= taken_count_d;
            branch_count_q <= branch_count_d;
        end
    end

    assign taken_count  = taken_count_q;
    assign branch_count = branch_count_q;
`endif

endmodule

// File: tb/tb_branching_unit.sv
// Self-checking bench for branching_unit: directed scenarios plus randomized
// traffic compared against a behavioural model of the branch rules.
`timescale 1ns/1ps
module tb_branching_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc = '0, read_data1 = '0, label = '0;
    logic [4:0]  fcode = '0;
    logic        branch = 1'b0, branchSrc = 1'b0, sign = 1'b0, zero = 1'b0, carry = 1'b0;
    logic [31:0] next_pc, writeRegData;
    logic        taken, illegal;
`ifdef BRANCH_STATS_EN
    logic [31:0] taken_count, branch_count;
`endif

    int checks = 0;
    int errors = 0;

    branching_unit #(.WIDTH(32), .PC_INC(4)) dut (
        .clk(clk), .rst_n(rst_n), .pc(pc), .read_data1(read_data1), .label(label),
        .fcode(fcode), .branch(branch), .branchSrc(branchSrc),
        .sign(sign), .zero(zero), .carry(carry),
`ifdef BRANCH_STATS_EN
        .taken_count(taken_count), .branch_count(branch_count),
`endif
        .next_pc(next_pc), .writeRegData(writeRegData), .taken(taken), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // Reference: the branch rule table written out directly.
    function automatic bit ref_cond(input int code, input bit s, input bit z, input bit c);
        if (code == 0 || code == 6) return 1'b1;
        if (code == 1) return c;
        if (code == 2) return !c;
        if (code == 3) return z;
        if (code == 4) return s;
        if (code == 5) return !z;
        return 1'b0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input string name, input logic [31:0] exp_pc,
                                 input logic [31:0] exp_link, input logic exp_taken,
                                 input logic exp_illegal);
        checks++;
        if (next_pc !== exp_pc || writeRegData !== exp_link ||
            taken !== exp_taken || illegal !== exp_illegal) begin
            errors++;
            $display("FAIL %s: got next_pc=%0d link=%0d taken=%b illegal=%b, want next_pc=%0d link=%0d taken=%b illegal=%b",
                     name, next_pc, writeRegData, taken, illegal,
                     exp_pc, exp_link, exp_taken, exp_illegal);
        end else begin
            $display("ok %s: next_pc=%0d link=%0d taken=%b illegal=%b",
                     name, next_pc, writeRegData, taken, illegal);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; pc = 32'd100; branch = 1'b1; fcode = 5'd0;
        branchSrc = 1'b1; label = 32'd5000; read_data1 = 32'd7;
        step(); step();
        check_outputs("reset_hold", 32'd0, 32'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step();
        check_outputs("reset_release", 32'd5000, 32'd104, 1'b1, 1'b0);
        // Asynchronous assertion must clear outputs before any clock edge.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_outputs("reset_async", 32'd0, 32'd0, 1'b0, 1'b0);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_label_sweep();
        logic [31:0] exp_pc [6];
        exp_pc = '{32'd10000, 32'd10000, 32'd104, 32'd104, 32'd10000, 32'd10000};
        rst_n = 1'b0;
        pc = 32'd100; read_data1 = 32'd200; label = 32'd10000;
        branch = 1'b1; branchSrc = 1'b1; sign = 1'b1; zero = 1'b0; carry = 1'b1;
        #1 rst_n = 1'b1;
        for (int f = 0; f < 6; f++) begin
            fcode = 5'(f);
            step();
            check_outputs($sformatf("label_f%0d", f), exp_pc[f], 32'd104,
                          exp_pc[f] == 32'd10000, 1'b0);
        end
`ifdef BRANCH_STATS_EN
        checks++;
        if (taken_count !== 32'd4 || branch_count !== 32'd6) begin
            errors++;
            $display("FAIL stats_sweep: got taken_count=%0d branch_count=%0d, want 4 and 6",
                     taken_count, branch_count);
        end else begin
            $display("ok stats_sweep: taken_count=%0d branch_count=%0d", taken_count, branch_count);
        end
`endif
    endtask

    task automatic test_reg_sweep();
        logic [31:0] exp_pc [7];
        exp_pc = '{32'd200, 32'd104, 32'd200, 32'd200, 32'd104, 32'd104, 32'd200};
        branch = 1'b1; branchSrc = 1'b0; sign = 1'b0; zero = 1'b1; carry = 1'b0;
        for (int f = 0; f < 7; f++) begin
            fcode = 5'(f);
            step();
            check_outputs($sformatf("reg_f%0d", f), exp_pc[f], 32'd104,
                          exp_pc[f] == 32'd200, 1'b0);
        end
    endtask

    task automatic test_no_branch();
        branch = 1'b0; branchSrc = 1'b1;
        for (int f = 0; f < 7; f++) begin
            fcode = 5'(f);
            sign = f[0]; zero = f[1]; carry = f[2];
            step();
            check_outputs($sformatf("nobranch_f%0d", f), 32'd104, 32'd104, 1'b0, 1'b0);
        end
    endtask

    task automatic test_illegal_wrap();
        branch = 1'b1; branchSrc = 1'b1; sign = 1'b1; zero = 1'b1; carry = 1'b1;
        fcode = 5'd7;
        step();
        check_outputs("illegal_f7", 32'd104, 32'd104, 1'b0, 1'b1);
        fcode = 5'd31;
        step();
        check_outputs("illegal_f31", 32'd104, 32'd104, 1'b0, 1'b1);
        pc = 32'hFFFF_FFFC; branch = 1'b0;
        step();
        check_outputs("pc_wrap", 32'd0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            logic [31:0] e_seq, e_tgt, e_pc;
            bit e_take, e_ill;
            pc = $urandom & 32'hFFFF_FFFC;
            if (i % 37 == 0) pc = 32'hFFFF_FFFC;
            read_data1 = $urandom; label = $urandom;
            fcode = 5'($urandom_range(0, 31));
            if (i % 3 != 0) fcode = 5'($urandom_range(0, 6));
            branch = 1'($urandom); branchSrc = 1'($urandom);
            sign = 1'($urandom); zero = 1'($urandom); carry = 1'($urandom);
            e_seq  = 32'((64'(pc) + 64'd4) % 64'h1_0000_0000);
            e_tgt  = branchSrc ? label : read_data1;
            e_take = branch && ref_cond(int'(fcode), sign, zero, carry);
            e_ill  = branch && (int'(fcode) >= 7);
            e_pc   = e_take ? e_tgt : e_seq;
            step();
            check_outputs($sformatf("rand%0d", i), e_pc, e_seq, e_take, e_ill);
        end
    endtask

    initial begin
        test_reset();
        test_label_sweep();
        test_reg_sweep();
        test_no_branch();
        test_illegal_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
